conv_result_collector: RTL and testbench

//   Sink end of the CNN window pipeline. Takes one convolution result per input pixel position,

---
 rtl/conv_result_collector.sv | 126 ++++++++++++
 tb/tb_conv_result_collector.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_collector.sv
// Sink stage of the CNN window pipeline: drops warm-up positions, clamps/shifts results,
// and buffers them in a small FIFO feeding a valid/ready stream with row/frame-end tags.
module conv_result_collector #(
  parameter int unsigned ROW_SIZE   = 10,
  parameter int unsigned NUM_ROWS   = 10,
  parameter int unsigned KERNEL     = 3,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned RELU       = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_last_col,
  output logic                 out_last
);

  localparam int unsigned ColW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned RowW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntW = WORD_SIZE + 2;

  localparam logic signed [ACC_WIDTH-1:0] MaxVal = ACC_WIDTH'((1 << WORD_SIZE) - 1);
  // The output is unsigned, so negatives clamp to zero whichever way RELU is set.
  localparam bit ClampNeg = (RELU != 0) || (RELU == 0);

  logic [ColW-1:0] col;
  logic [RowW-1:0] row;
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic [EntW-1:0] mem [FIFO_DEPTH];

  logic                        accept;
  logic                        keep;
  logic                        push;
  logic                        pop;
  logic                        at_last_col;
  logic                        at_last_row;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [WORD_SIZE-1:0]        sat;
  logic [EntW-1:0]             head;

  assign in_ready    = (count != CntW'(FIFO_DEPTH));
  assign out_valid   = (count != '0);
  assign accept      = in_valid & in_ready;
  assign at_last_col = (col == ColW'(ROW_SIZE - 1));
  assign at_last_row = (row == RowW'(NUM_ROWS - 1));
  assign keep        = (row >= RowW'(KERNEL - 1)) && (col >= ColW'(KERNEL - 1));
  assign push        = accept & keep;
  assign pop         = out_valid & out_ready;

  assign shifted = $signed(in_data) >>> SHIFT;

  always_comb begin
    sat = '0;
    if (ClampNeg && shifted[ACC_WIDTH-1]) begin
      sat = '0;
    end else if (shifted > MaxVal) begin
      sat = '1;
    end else begin
      sat = shifted[WORD_SIZE-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_last_col) begin
        col <= '0;
        row <= at_last_row ? '0 : row + RowW'(1);
      end else begin
        col <= col + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the head is masked while empty so outputs read zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {sat, at_last_col, at_last_col & at_last_row};
    end
  end

  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem[rd_ptr];
    end
  end

  assign out_data     = head[EntW-1:2];
  assign out_last_col = head[1];
  assign out_last     = head[0];

endmodule

// File: tb/tb_conv_result_collector.sv
// Randomised and directed bench for conv_result_collector: three parameterisations checked
// cycle by cycle against a queue-based model of the kept/clamped output stream.
module tb_conv_result_collector;

  typedef struct {
    int data;
    bit lc;
    bit l;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]        iv   = '0;
  logic [2:0]        ordy = '0;
  logic [2:0][19:0]  d    = '0;
  wire  [2:0]        ir;
  wire  [2:0]        ov;
  wire  [2:0]        olc;
  wire  [2:0]        ol;
  wire  [2:0][7:0]   od;

  conv_result_collector u_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_last_col(olc[0]),
    .out_last(ol[0])
  );

  conv_result_collector #(.SHIFT(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_last_col(olc[1]),
    .out_last(ol[1])
  );

  conv_result_collector #(.ROW_SIZE(5), .NUM_ROWS(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(d[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_last_col(olc[2]),
    .out_last(ol[2])
  );

  int total = 0;
  int bad   = 0;
  ent_t q[$];
  int   got[$];
  int   pos[3];
  int   outs, lasts, lcs;

  logic       held_v = 1'b0;
  int         held_k;
  logic [7:0] held_d;
  logic       held_lc, held_l;

  function automatic int cols_of(input int k);
    return (k == 2) ? 5 : 10;
  endfunction

  function automatic int rows_of(input int k);
    return (k == 2) ? 4 : 10;
  endfunction

  function automatic int shift_of(input int k);
    return (k == 1) ? 2 : 0;
  endfunction

  // Output pixel from the arithmetic rules: floor-divide, clamp to [0,255].
  function automatic int expv(input int data, input int sh);
    int v;
    if (data < 0) return 0;
    v = data / (1 << sh);
    if (v > 255) v = 255;
    return v;
  endfunction

  function automatic int data_of(input int k, input int idx, input int mode);
    if (mode == 2) return int'($urandom_range(0, 700)) - 200;
    if (mode == 1 && idx == 22) return (k == 1) ? 1023 : 300;
    if (mode == 1 && idx == 23) return (k == 1) ? 40 : -5;
    return idx;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    outs = 0;
    lasts = 0;
    lcs = 0;
    got.delete();
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic cycle(input int k, input logic v, input int data, input logic r,
                       output logic acc);
    int sz, rr, cc;
    ent_t e;
    @(negedge clk);
    iv[k] = v;
    d[k] = 20'(data);
    ordy[k] = r;
    #1;
    sz = q.size();
    if (held_v && held_k == k) begin
      check("stall_valid", 32'(ov[k]), 32'd1);
      check("stall_data", 32'(od[k]), 32'(held_d));
      check("stall_tags", {30'd0, olc[k], ol[k]}, {30'd0, held_lc, held_l});
    end
    check("out_valid", 32'(ov[k]), 32'(sz != 0));
    check("in_ready", 32'(ir[k]), 32'(sz < 4));
    if (sz != 0) begin
      check("out_data", 32'(od[k]), 32'(q[0].data));
      check("out_last_col", 32'(olc[k]), 32'(q[0].lc));
      check("out_last", 32'(ol[k]), 32'(q[0].l));
    end
    held_v = ov[k] && !r;
    held_k = k;
    held_d = od[k];
    held_lc = olc[k];
    held_l = ol[k];
    if (sz != 0 && r) begin
      outs++;
      if (q[0].l) lasts++;
      if (q[0].lc) lcs++;
      got.push_back(int'(od[k]));
      void'(q.pop_front());
    end
    acc = v && (sz < 4);
    if (acc) begin
      rr = pos[k] / cols_of(k);
      cc = pos[k] % cols_of(k);
      if (rr >= 2 && cc >= 2) begin
        e.data = expv(data, shift_of(k));
        e.lc = (cc == cols_of(k) - 1);
        e.l = e.lc && (rr == rows_of(k) - 1);
        q.push_back(e);
      end
      pos[k] = (pos[k] + 1) % (cols_of(k) * rows_of(k));
    end
    @(posedge clk);
  endtask

  task automatic run(input int k, input int start, input int n, input int mode, input bit rnd);
    int fed, cyc, cur;
    logic acc, v, r;
    fed = 0;
    cyc = 0;
    cur = data_of(k, start, mode);
    while (fed < n && cyc < 5000) begin
      v = rnd ? logic'($urandom_range(0, 1)) : 1'b1;
      r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle(k, v, cur, r, acc);
      if (acc) begin
        fed++;
        cur = data_of(k, start + fed, mode);
      end
      cyc++;
    end
    check("feed_done", 32'(fed), 32'(n));
  endtask

  task automatic drain(input int k);
    int c;
    logic acc;
    c = 0;
    while (q.size() != 0 && c < 100) begin
      cycle(k, 1'b0, 0, 1'b1, acc);
      c++;
    end
    check("drained", 32'(q.size()), 32'd0);
    cycle(k, 1'b0, 0, 1'b1, acc);
    iv[k] = 1'b0;
    ordy[k] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    iv = '0;
    ordy = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", 32'(ov[k]), 32'd0);
      check("rst_in_ready", 32'(ir[k]), 32'd1);
      check("rst_out_data", 32'(od[k]), 32'd0);
      check("rst_tags", {30'd0, olc[k], ol[k]}, 32'd0);
    end
    q.delete();
    for (int k = 0; k < 3; k++) pos[k] = 0;
    held_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int fed, c;
    logic acc;

    do_reset();

    // Ramp frame through the default instance.
    clear_stats();
    run(0, 0, 100, 0, 1'b0);
    drain(0);
    check("t1_outs", 32'(outs), 32'd64);
    check("t1_last_col", 32'(lcs), 32'd8);
    check("t1_last", 32'(lasts), 32'd1);
    check("t1_first", 32'(got.size() > 0 ? got[0] : -1), 32'd22);
    check("t1_final", 32'(got.size() > 63 ? got[63] : -1), 32'd99);

    // Saturation and negative clamp.
    clear_stats();
    run(0, 0, 100, 1, 1'b0);
    drain(0);
    check("t2_sat", 32'(got.size() > 0 ? got[0] : -1), 32'd255);
    check("t2_neg", 32'(got.size() > 1 ? got[1] : -1), 32'd0);
    clear_stats();
    run(1, 0, 100, 1, 1'b0);
    drain(1);
    check("t2_shift_sat", 32'(got.size() > 0 ? got[0] : -1), 32'd255);
    check("t2_shift_div", 32'(got.size() > 1 ? got[1] : -1), 32'd10);
    check("t2_outs", 32'(outs), 32'd64);

    // Back-pressure until the FIFO fills, then release.
    clear_stats();
    fed = 0;
    c = 0;
    while (fed < 26 && c < 200) begin
      cycle(0, 1'b1, fed, 1'b0, acc);
      if (acc) fed++;
      c++;
    end
    check("t3_fed_before_full", 32'(fed), 32'd26);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1'b1, fed, 1'b0, acc);
      check("t3_stalled", 32'(acc), 32'd0);
    end
    run(0, 26, 74, 0, 1'b0);
    drain(0);
    check("t3_outs", 32'(outs), 32'd64);
    check("t3_first", 32'(got.size() > 0 ? got[0] : -1), 32'd22);
    check("t3_final", 32'(got.size() > 63 ? got[63] : -1), 32'd99);

    // Random traffic over three frames.
    clear_stats();
    run(0, 0, 300, 2, 1'b1);
    drain(0);
    check("t4_outs", 32'(outs), 32'd192);
    check("t4_last", 32'(lasts), 32'd3);

    // Mid-frame reset with two entries queued.
    clear_stats();
    run(0, 0, 48, 0, 1'b0);
    drain(0);
    cycle(0, 1'b1, 48, 1'b0, acc);
    cycle(0, 1'b1, 49, 1'b0, acc);
    cycle(0, 1'b0, 0, 1'b0, acc);
    check("t5_queued_valid", 32'(ov[0]), 32'd1);
    do_reset();
    clear_stats();
    run(0, 0, 100, 0, 1'b0);
    drain(0);
    check("t5_outs", 32'(outs), 32'd64);
    check("t5_first", 32'(got.size() > 0 ? got[0] : -1), 32'd22);

    // Small frame geometry.
    clear_stats();
    run(2, 0, 20, 0, 1'b0);
    drain(2);
    check("t6_outs", 32'(outs), 32'd6);
    check("t6_last_col", 32'(lcs), 32'd2);
    check("t6_last", 32'(lasts), 32'd1);
    check("t6_first", 32'(got.size() > 0 ? got[0] : -1), 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
